microc_ctrl_fsm: RTL and testbench



---
 rtl/microc_pkg.sv | 31 +++
 rtl/microc_ctrl_fsm_if.sv | 27 ++
 rtl/microc_ctrl_dec.sv | 39 +++
 rtl/microc_ctrl_fsm.sv | 96 +++++++++
 tb/tb_microc_ctrl_fsm.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/microc_pkg.sv
// Shared opcodes, ALU op encodings, FSM state type and decoder bundle for the
// microc control unit.
package microc_pkg;

  localparam logic [5:0] OPC_LI   = 6'b100000;  // low two bits are don't-care
  localparam logic [5:0] OPC_J    = 6'b100100;
  localparam logic [5:0] OPC_JZ   = 6'b100101;
  localparam logic [5:0] OPC_JNZ  = 6'b100110;
  localparam logic [5:0] OPC_HALT = 6'b111111;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
    logic       is_halt;
    logic       is_illegal;
  } dec_t;

endpackage

// File: rtl/microc_ctrl_fsm_if.sv
// Control/status bundle between the microc datapath (master) and the
// control unit (slave).
interface microc_ctrl_fsm_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             z;
  logic             s_inc;
  logic             s_inm;
  logic             we3;
  logic             wez;
  logic [2:0]       op;
  logic             pc_we;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output opcode, z,
    input  s_inc, s_inm, we3, wez, op, pc_we, halted, illegal, instr_cnt
  );

  modport slave (
    input  opcode, z,
    output s_inc, s_inm, we3, wez, op, pc_we, halted, illegal, instr_cnt
  );
endinterface

// File: rtl/microc_ctrl_dec.sv
// Combinational instruction decoder: maps the latched opcode and live zero
// flag to datapath strobes plus halt/illegal classification.
module microc_ctrl_dec
  import microc_pkg::*;
#(
  parameter logic [5:0] HALT_OPC = OPC_HALT
) (
  input  logic [5:0] ir_i,
  input  logic       z_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o       = '0;
    dec_o.s_inc = 1'b1;
    dec_o.op    = ALU_PASS;
    // Halt is tested first so an overridden HALT_OPC wins over any other class.
    if (ir_i == HALT_OPC) begin
      dec_o.s_inc   = 1'b0;
      dec_o.is_halt = 1'b1;
    end else if (!ir_i[5]) begin
      dec_o.op  = ir_i[4:2];
      dec_o.we3 = 1'b1;
      dec_o.wez = 1'b1;
    end else if (ir_i[5:2] == OPC_LI[5:2]) begin
      dec_o.s_inm = 1'b1;
      dec_o.we3   = 1'b1;
    end else if (ir_i == OPC_J) begin
      dec_o.s_inc = 1'b0;
    end else if (ir_i == OPC_JZ) begin
      dec_o.s_inc = ~z_i;
    end else if (ir_i == OPC_JNZ) begin
      dec_o.s_inc = z_i;
    end else begin
      dec_o.is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/microc_ctrl_fsm.sv
// microc multicycle control unit: FETCH/EXEC sequencing, halt, sticky illegal
// flag and retired-instruction counter. MICROC_CTRL_STEP_EN adds a step input.
module microc_ctrl_fsm
  import microc_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [5:0] HALT_OPC = OPC_HALT
) (
  input  logic clk,
  input  logic reset,
`ifdef MICROC_CTRL_STEP_EN
  input  logic step,
`endif
  microc_ctrl_fsm_if.slave bus
);

  state_e           state_q, state_d;
  logic [5:0]       ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;
  logic             advance;
  dec_t             dec;

`ifdef MICROC_CTRL_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  microc_ctrl_dec #(.HALT_OPC(HALT_OPC)) u_dec (
    .ir_i  (ir_q),
    .z_i   (bus.z),
    .dec_o (dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    case (state_q)
      S_FETCH: begin
        if (advance) begin
          ir_d    = bus.opcode;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec.is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          cnt_d   = cnt_q + CNT_W'(1);
          if (dec.is_illegal) ill_d = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.s_inc     = 1'b0;
    bus.s_inm     = 1'b0;
    bus.we3       = 1'b0;
    bus.wez       = 1'b0;
    bus.op        = ALU_PASS;
    bus.pc_we     = 1'b0;
    bus.halted    = (state_q == S_HALT);
    bus.illegal   = ill_q;
    bus.instr_cnt = cnt_q;
    if (state_q == S_EXEC) begin
      bus.s_inc = dec.s_inc;
      bus.s_inm = dec.s_inm;
      bus.we3   = dec.we3;
      bus.wez   = dec.wez;
      bus.op    = dec.op;
      bus.pc_we = ~dec.is_halt;
    end
  end

endmodule

// File: tb/tb_microc_ctrl_fsm.sv
// Directed bench for microc_ctrl_fsm (counter width 4 to reach the wrap);
// step scenario only built with MICROC_CTRL_STEP_EN.
module tb_microc_ctrl_fsm;
  import microc_pkg::*;

  logic clk = 1'b0;
  logic reset;
`ifdef MICROC_CTRL_STEP_EN
  logic step;
`endif
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] exp_cnt;
  logic       exp_ill;
  logic [9:0] ctl;

  always #5 clk = ~clk;

  microc_ctrl_fsm_if #(.CNT_W(4)) bus ();

  microc_ctrl_fsm #(.CNT_W(4), .HALT_OPC(6'b111111)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef MICROC_CTRL_STEP_EN
    .step  (step),
`endif
    .bus   (bus)
  );

  // {s_inc, s_inm, we3, wez, op[2:0], pc_we, halted, illegal}
  assign ctl = {bus.s_inc, bus.s_inm, bus.we3, bus.wez, bus.op,
                bus.pc_we, bus.halted, bus.illegal};

  task automatic go_exec(input logic [5:0] opc, input logic zv);
    bus.opcode = opc;
    bus.z      = zv;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (ctl !== 10'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, 10'b0); end
    n_cmp++; if (bus.instr_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bus.instr_cnt); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (ctl !== 10'b0) begin n_bad++; $display("FAIL post_reset_fetch: got %b want %b", ctl, 10'b0); end
    go_exec(OPC_LI, 1'b0);
    n_cmp++; if (ctl !== 10'b1110_000_100) begin n_bad++; $display("FAIL li_before_reset: got %b want %b", ctl, 10'b1110000100); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (ctl !== 10'b0) begin n_bad++; $display("FAIL async_reset_ctl: got %b want %b", ctl, 10'b0); end
    n_cmp++; if (bus.instr_cnt !== 4'd0) begin n_bad++; $display("FAIL async_reset_cnt: got %0d want 0", bus.instr_cnt); end
    #4 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (ctl !== 10'b0) begin n_bad++; $display("FAIL reset_first_fetch: got %b want %b", ctl, 10'b0); end
    exp_cnt = '0;
    exp_ill = 1'b0;
  endtask

  task automatic test_li();
    go_exec(6'b100011, 1'b1);
    n_cmp++; if (ctl !== {10'b1110_000_100 | {9'b0, exp_ill}}) begin n_bad++; $display("FAIL li_exec: got %b want %b", ctl, {10'b1110000100 | {9'b0, exp_ill}}); end
    n_cmp++; if (bus.instr_cnt !== exp_cnt) begin n_bad++; $display("FAIL li_cnt_exec: got %0d want %0d", bus.instr_cnt, exp_cnt); end
    @(negedge clk);
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++; if (bus.instr_cnt !== exp_cnt) begin n_bad++; $display("FAIL li_cnt_after: got %0d want %0d", bus.instr_cnt, exp_cnt); end
    n_cmp++; if (ctl !== {9'b0, exp_ill}) begin n_bad++; $display("FAIL li_next_fetch: got %b want %b", ctl, {9'b0, exp_ill}); end
  endtask

  task automatic test_alu();
    logic [5:0] opcs [2];
    logic [2:0] ops  [2];
    opcs[0] = 6'b001000; ops[0] = ALU_ADD;
    opcs[1] = 6'b001100; ops[1] = ALU_SUB;
    for (int i = 0; i < 2; i++) begin
      go_exec(opcs[i], 1'b0);
      n_cmp++; if (ctl !== {4'b1011, ops[i], 2'b10, exp_ill}) begin n_bad++; $display("FAIL alu_exec_%0d: got %b want %b", i, ctl, {4'b1011, ops[i], 2'b10, exp_ill}); end
      @(negedge clk);
      exp_cnt = exp_cnt + 4'd1;
      n_cmp++; if (ctl !== {9'b0, exp_ill}) begin n_bad++; $display("FAIL alu_fetch_%0d: got %b want %b", i, ctl, {9'b0, exp_ill}); end
      n_cmp++; if (bus.instr_cnt !== exp_cnt) begin n_bad++; $display("FAIL alu_cnt_%0d: got %0d want %0d", i, bus.instr_cnt, exp_cnt); end
    end
  endtask

  task automatic test_jumps();
    logic [5:0] opcs [3];
    logic       inc0 [3];
    logic       inc1 [3];
    opcs[0] = OPC_JNZ; inc0[0] = 1'b0; inc1[0] = 1'b1;
    opcs[1] = OPC_JZ;  inc0[1] = 1'b1; inc1[1] = 1'b0;
    opcs[2] = OPC_J;   inc0[2] = 1'b0; inc1[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      go_exec(opcs[i], 1'b0);
      n_cmp++; if (ctl !== {inc0[i], 6'b0, 2'b10, exp_ill}) begin n_bad++; $display("FAIL jump_%0d_z0: got %b want %b", i, ctl, {inc0[i], 6'b0, 2'b10, exp_ill}); end
      bus.z = 1'b1;
      #1;
      n_cmp++; if (ctl !== {inc1[i], 6'b0, 2'b10, exp_ill}) begin n_bad++; $display("FAIL jump_%0d_z1: got %b want %b", i, ctl, {inc1[i], 6'b0, 2'b10, exp_ill}); end
      bus.z = 1'b0;
      @(negedge clk);
      exp_cnt = exp_cnt + 4'd1;
      n_cmp++; if (bus.instr_cnt !== exp_cnt) begin n_bad++; $display("FAIL jump_%0d_cnt: got %0d want %0d", i, bus.instr_cnt, exp_cnt); end
    end
  endtask

  task automatic test_illegal();
    go_exec(6'b110000, 1'b0);
    n_cmp++; if (ctl !== {7'b1000_000, 3'b100}) begin n_bad++; $display("FAIL illegal_exec: got %b want %b", ctl, 10'b1000000100); end
    @(negedge clk);
    exp_cnt = exp_cnt + 4'd1;
    exp_ill = 1'b1;
    n_cmp++; if (ctl !== 10'b0000_000_001) begin n_bad++; $display("FAIL illegal_sticky_fetch: got %b want %b", ctl, 10'b1); end
    test_li();
    test_li();
    n_cmp++; if (bus.illegal !== 1'b1) begin n_bad++; $display("FAIL illegal_stays: got %b want 1", bus.illegal); end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = '0;
    exp_ill = 1'b0;
    n_cmp++; if (ctl !== 10'b0) begin n_bad++; $display("FAIL wrap_reset_ctl: got %b want %b", ctl, 10'b0); end
    for (int i = 0; i < 16; i++) begin
      go_exec(6'b110000, 1'b0);
      @(negedge clk);
      if (i == 14) begin
        n_cmp++; if (bus.instr_cnt !== 4'd15) begin n_bad++; $display("FAIL wrap_cnt15: got %0d want 15", bus.instr_cnt); end
      end
    end
    exp_ill = 1'b1;
    n_cmp++; if (bus.instr_cnt !== 4'd0) begin n_bad++; $display("FAIL wrap_cnt0: got %0d want 0", bus.instr_cnt); end
  endtask

`ifdef MICROC_CTRL_STEP_EN
  task automatic test_step();
    step = 1'b0;
    bus.opcode = OPC_LI;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (ctl !== {9'b0, exp_ill}) begin n_bad++; $display("FAIL step_hold_%0d: got %b want %b", i, ctl, {9'b0, exp_ill}); end
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    n_cmp++; if (ctl !== {10'b1110_000_100 | {9'b0, exp_ill}}) begin n_bad++; $display("FAIL step_exec: got %b want %b", ctl, {10'b1110000100 | {9'b0, exp_ill}}); end
    @(negedge clk);
    @(negedge clk);
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++; if (ctl !== {9'b0, exp_ill}) begin n_bad++; $display("FAIL step_one_only: got %b want %b", ctl, {9'b0, exp_ill}); end
    n_cmp++; if (bus.instr_cnt !== exp_cnt) begin n_bad++; $display("FAIL step_cnt: got %0d want %0d", bus.instr_cnt, exp_cnt); end
    step = 1'b1;
  endtask
`endif

  task automatic test_halt();
    go_exec(OPC_HALT, 1'b0);
    n_cmp++; if (ctl !== {9'b0, exp_ill}) begin n_bad++; $display("FAIL halt_exec: got %b want %b", ctl, {9'b0, exp_ill}); end
    for (int i = 0; i < 22; i++) begin
      bus.opcode = (i % 2 == 0) ? OPC_LI : 6'b001000;
      bus.z      = i[0];
      @(negedge clk);
      n_cmp++; if (ctl !== {8'b0, 1'b1, exp_ill}) begin n_bad++; $display("FAIL halt_hold_%0d: got %b want %b", i, ctl, {8'b0, 1'b1, exp_ill}); end
      n_cmp++; if (bus.instr_cnt !== exp_cnt) begin n_bad++; $display("FAIL halt_cnt_%0d: got %0d want %0d", i, bus.instr_cnt, exp_cnt); end
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (ctl !== 10'b0) begin n_bad++; $display("FAIL halt_reset_ctl: got %b want %b", ctl, 10'b0); end
    n_cmp++; if (bus.instr_cnt !== 4'd0) begin n_bad++; $display("FAIL halt_reset_cnt: got %0d want 0", bus.instr_cnt); end
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = '0;
    exp_ill = 1'b0;
    test_li();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.opcode = '0;
    bus.z      = 1'b0;
    exp_cnt    = '0;
    exp_ill    = 1'b0;
`ifdef MICROC_CTRL_STEP_EN
    step = 1'b1;
`endif
    test_reset();
    test_li();
    test_alu();
    test_jumps();
    test_illegal();
    test_wrap();
`ifdef MICROC_CTRL_STEP_EN
    test_step();
`endif
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
